fft32_input_loader: RTL

FFT32_INPUT_LOADER -- requirements
Module: fft32_input_loader

---
 rtl/fft32_input_loader_pkg.sv | 33 +++
 rtl/fft32_input_loader_bitrev5.sv | 18 +
 rtl/fft32_input_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/fft32_input_loader_pkg.sv
// Shared constants and helper types for the 32-point FFT input loader.
// The output unloader imports the same package, so frame length and index
// width are defined in one place.
package fft32_input_loader_pkg;

  // Frame geometry: 32 points, 5-bit sample index.
  localparam int FFT_N                  = 32;
  localparam int FFT_LOG2N              = 5;
  localparam int FFT_DEFAULT_DATA_WIDTH = 16;

  // Index of the final sample in a frame.
  localparam logic [FFT_LOG2N-1:0] FFT_LAST_IDX = FFT_LOG2N'(FFT_N - 1);

  // How an accepted sample relates to the framing rules.
  typedef enum logic [1:0] {
    SAMPLE_OK,           // mid-frame sample, in_last low
    SAMPLE_DONE,         // 32nd sample with in_last high, frame complete
    SAMPLE_EARLY_LAST,   // in_last high before the 32nd sample
    SAMPLE_MISSING_LAST  // 32nd sample without in_last
  } sample_kind_e;

  // Classify a sample from its position in the frame and its in_last flag.
  function automatic sample_kind_e classify_sample(
    input logic [FFT_LOG2N-1:0] cnt,
    input logic                 last
  );
    if (cnt == FFT_LAST_IDX) begin
      return last ? SAMPLE_DONE : SAMPLE_MISSING_LAST;
    end
    return last ? SAMPLE_EARLY_LAST : SAMPLE_OK;
  endfunction

endpackage

// File: rtl/fft32_input_loader_bitrev5.sv
// Purely combinational 5-bit index reversal. Shared between the input
// loader (write lane selection) and the output unloader.
module fft32_bitrev5
  import fft32_input_loader_pkg::*;
(
  input  logic [FFT_LOG2N-1:0] idx,
  output logic [FFT_LOG2N-1:0] rev
);

  // Mirror the index bits: bit b of the result is bit (LOG2N-1-b) of idx.
  always_comb begin
    rev = '0;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      rev[b] = idx[FFT_LOG2N-1-b];
    end
  end

endmodule

// File: rtl/fft32_input_loader.sv
// Serial-to-parallel loader for the 32-point FFT. Samples arrive one per
// handshake and are scattered into bit-reversed lanes of a ping-pong pair of
// frame banks, so lane k of a finished frame holds time sample bitrev5(k).
// One bank can be filled while the other is presented downstream.
// Only N = 32 is supported; N sizes the lane arrays.
module fft32_input_loader
  import fft32_input_loader_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DEFAULT_DATA_WIDTH,
  parameter int N          = FFT_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [N*DATA_WIDTH-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_err
);

  logic [FFT_LOG2N-1:0]  cnt;
  logic [FFT_LOG2N-1:0]  wr_lane;
  logic                  wr_sel;
  logic                  rd_sel;
  logic [1:0]            full;
  logic [1:0]            full_next;
  logic                  accept;
  logic                  drain;
  sample_kind_e          kind;
  logic [DATA_WIDTH-1:0] bank_mem [2][N];

  fft32_bitrev5 u_bitrev (
    .idx (cnt),
    .rev (wr_lane)
  );

  // Handshakes and status derive only from registered flags, so in_ready
  // never reacts combinationally to a drain in the same cycle.
  always_comb begin
    in_ready    = !full[wr_sel];
    frame_valid = full[rd_sel];
    accept      = in_valid && in_ready;
    drain       = frame_valid && frame_ready;
    kind        = classify_sample(cnt, in_last);
  end

  // Next bank-full flags: a drain and a completing sample always target
  // different banks, so both updates can apply in the same cycle.
  always_comb begin
    full_next = full;
    if (drain) begin
      full_next[rd_sel] = 1'b0;
    end
    if (accept && (kind == SAMPLE_DONE)) begin
      full_next[wr_sel] = 1'b1;
    end
  end

  // Frame control: sample counter, bank pointers, full flags, error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      full      <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      full      <= full_next;
      frame_err <= 1'b0;
      if (drain) begin
        rd_sel <= ~rd_sel;
      end
      if (accept) begin
        unique case (kind)
          SAMPLE_OK: begin
            cnt <= cnt + FFT_LOG2N'(1);
          end
          SAMPLE_DONE: begin
            cnt    <= '0;
            wr_sel <= ~wr_sel;
          end
          default: begin
            cnt       <= '0;
            frame_err <= 1'b1;
          end
        endcase
      end
    end
  end

  // Bank storage: each accepted sample lands in its bit-reversed lane of the
  // write bank. Samples of a discarded frame are simply overwritten later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_mem[b][k] <= '0;
        end
      end
    end else if (accept) begin
      bank_mem[wr_sel][wr_lane] <= in_data;
    end
  end

  // Present the read bank as a flat lane vector, lane k at bits k*DATA_WIDTH.
  always_comb begin
    frame_data = '0;
    for (int k = 0; k < N; k++) begin
      frame_data[k*DATA_WIDTH +: DATA_WIDTH] = bank_mem[rd_sel][k];
    end
  end

endmodule
